// File: rtl/affine_sample_window.sv
// Sliding 6-sample window feeder for the affine 6-tap MCM filters, with edge replication.
// Optional build macro AFFINE_WIN_COL_EN adds out_col (centre index of each window).
module affine_sample_window #(
  parameter int IN_SIZE = 8,
  parameter int LEN_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [IN_SIZE-1:0] in_data,
  input  logic                      in_sol,
  input  logic                      in_eol,
  input  logic [3:0]                frac_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [IN_SIZE-1:0] out_x0,
  output logic signed [IN_SIZE-1:0] out_x1,
  output logic signed [IN_SIZE-1:0] out_x2,
  output logic signed [IN_SIZE-1:0] out_x3,
  output logic signed [IN_SIZE-1:0] out_x4,
  output logic signed [IN_SIZE-1:0] out_x5,
  output logic [3:0]                out_frac,
`ifdef AFFINE_WIN_COL_EN
  output logic [LEN_W-1:0]          out_col,
`endif
  output logic                      out_eol
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t                    state, state_nxt;
  logic signed [IN_SIZE-1:0] win_p0 [6];
  logic signed [IN_SIZE-1:0] shift_p0 [6];
  logic signed [IN_SIZE-1:0] win_p1 [6];
  logic signed [IN_SIZE-1:0] ins;
  logic [LEN_W-1:0]          j_p0, j_nxt, end_p0, end_nxt;
  logic [3:0]                frac_p0, frac_nxt, frac_p1;
  logic                      vld_p1, eol_p1;
  logic                      free, rdy, start, step, load, emit, last;
`ifdef AFFINE_WIN_COL_EN
  logic [LEN_W-1:0]          col_p1;
`endif

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v == {LEN_W{1'b1}}) ? v : v + LEN_W'(1);
  endfunction

  assign free     = !vld_p1 || out_ready;
  assign in_ready = rst_n && rdy;

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    start     = 1'b0;
    step      = 1'b0;
    load      = 1'b0;
    emit      = 1'b0;
    last      = 1'b0;
    ins       = in_data;
    j_nxt     = j_p0;
    end_nxt   = end_p0;
    frac_nxt  = frac_p0;
    case (state)
      IDLE: begin
        rdy   = 1'b1;
        start = in_valid && in_sol;
      end
      FILL, RUN: begin
        // the shift that completes the fill emits, so it needs a free output slot
        rdy   = (state == RUN || j_p0 == LEN_W'(2)) ? free : 1'b1;
        start = in_valid && rdy && in_sol;
        step  = in_valid && rdy && !in_sol;
      end
      FLUSH: begin
        step = free;
        ins  = win_p0[5];
      end
      default: ;
    endcase
    if (start) begin
      load      = 1'b1;
      j_nxt     = '0;
      frac_nxt  = frac_in;
      end_nxt   = LEN_W'(3);
      state_nxt = in_eol ? FLUSH : FILL;
    end
    if (step) begin
      j_nxt = sat_inc(j_p0);
      emit  = (j_nxt >= LEN_W'(3));
      if (state == FLUSH) begin
        if (j_nxt == end_p0) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end else if (in_eol) begin
        // sample index is j+1, so the final shift count N+2 equals j+4
        end_nxt   = j_p0 + LEN_W'(4);
        state_nxt = FLUSH;
      end else if (emit) begin
        state_nxt = RUN;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++) shift_p0[i] = win_p0[i+1];
    shift_p0[5] = ins;
  end

  // stage p0: window and line control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      j_p0    <= '0;
      end_p0  <= '0;
      frac_p0 <= '0;
      for (int i = 0; i < 6; i++) win_p0[i] <= '0;
    end else begin
      state   <= state_nxt;
      j_p0    <= j_nxt;
      end_p0  <= end_nxt;
      frac_p0 <= frac_nxt;
      if (load) begin
        for (int i = 0; i < 6; i++) win_p0[i] <= in_data;
      end else if (step) begin
        for (int i = 0; i < 6; i++) win_p0[i] <= shift_p0[i];
      end
    end
  end

  // stage p1: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      eol_p1  <= 1'b0;
      frac_p1 <= '0;
      for (int i = 0; i < 6; i++) win_p1[i] <= '0;
`ifdef AFFINE_WIN_COL_EN
      col_p1  <= '0;
`endif
    end else if (emit) begin
      vld_p1  <= 1'b1;
      eol_p1  <= last;
      frac_p1 <= frac_p0;
      for (int i = 0; i < 6; i++) win_p1[i] <= shift_p0[i];
`ifdef AFFINE_WIN_COL_EN
      col_p1  <= j_nxt - LEN_W'(3);
`endif
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
      eol_p1  <= 1'b0;
      frac_p1 <= '0;
      for (int i = 0; i < 6; i++) win_p1[i] <= '0;
`ifdef AFFINE_WIN_COL_EN
      col_p1  <= '0;
`endif
    end
  end

  assign out_valid = vld_p1;
  assign out_eol   = eol_p1;
  assign out_frac  = frac_p1;
  assign out_x0    = win_p1[0];
  assign out_x1    = win_p1[1];
  assign out_x2    = win_p1[2];
  assign out_x3    = win_p1[3];
  assign out_x4    = win_p1[4];
  assign out_x5    = win_p1[5];
`ifdef AFFINE_WIN_COL_EN
  assign out_col   = col_p1;
`endif

endmodule

// File: tb/tb_affine_sample_window.sv
// Bench for affine_sample_window: directed scenarios plus random lines, scored against a
// clamped-index window model of each line.
module tb_affine_sample_window;

  localparam int IN_SIZE = 8;
  localparam int LEN_W   = 8;
  localparam int MAXLEN  = (1 << LEN_W) - 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_sol = 1'b0, in_eol = 1'b0, out_ready = 1'b1;
  logic signed [IN_SIZE-1:0] in_data = '0;
  logic [3:0] frac_in = '0;
  logic in_ready, out_valid, out_eol;
  logic signed [IN_SIZE-1:0] out_x0, out_x1, out_x2, out_x3, out_x4, out_x5;
  logic [3:0] out_frac;

  affine_sample_window #(.IN_SIZE(IN_SIZE), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sol(in_sol), .in_eol(in_eol), .frac_in(frac_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x0(out_x0), .out_x1(out_x1), .out_x2(out_x2),
    .out_x3(out_x3), .out_x4(out_x4), .out_x5(out_x5),
    .out_frac(out_frac), .out_eol(out_eol)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0, err_cnt = 0, n_win = 0, base = 0;
  bit hold = 1'b0, rdy_rand = 1'b0, active = 1'b0;
  logic [63:0] held;
  logic [63:0] exp_q[$];
  logic [7:0]  cur[$];
  logic [3:0]  cur_frac;
  logic [63:0] obs_win;

  assign obs_win = {11'd0, out_frac, out_eol, out_x0, out_x1, out_x2, out_x3, out_x4, out_x5};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Window centred on k: taps are s[k-2..k+3] with the index clamped into the line.
  function automatic logic [63:0] ref_win(input int k, input int n, input logic eol);
    logic [63:0] w;
    int idx;
    w = '0;
    for (int t = 0; t < 6; t++) begin
      idx = k - 2 + t;
      if (idx < 0) idx = 0;
      if (idx > n - 1) idx = n - 1;
      w = {w[55:0], cur[idx]};
    end
    return {11'd0, cur_frac, eol, w[47:0]};
  endfunction

  task automatic model_beat(input logic [7:0] d, input logic sol, input logic eol, input logic [3:0] fr);
    int n;
    bit take;
    take = 1'b1;
    if (sol) begin
      cur.delete();
      cur.push_back(d);
      cur_frac = fr;
      active = 1'b1;
    end else if (active) begin
      cur.push_back(d);
    end else begin
      take = 1'b0;
    end
    if (take) begin
      n = cur.size();
      assert (n <= MAXLEN) else $error("line length %0d exceeds %0d", n, MAXLEN);
      if (eol) begin
        for (int k = (n > 4 ? n - 4 : 0); k < n; k++) exp_q.push_back(ref_win(k, n, k == n - 1));
        active = 1'b0;
      end else if (n >= 4) begin
        exp_q.push_back(ref_win(n - 4, n, 1'b0));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) chk("hold", obs_win, held);
      hold = out_valid && !out_ready;
      held = obs_win;
      if (out_valid && out_ready) begin
        n_win++;
        if (exp_q.size() == 0) chk("win_extra", 64'(exp_q.size()), 64'd1);
        else chk("win", obs_win, exp_q.pop_front());
      end
      if (in_valid && in_ready) model_beat(in_data, in_sol, in_eol, frac_in);
    end
  end

  always @(posedge clk) begin
    if (rdy_rand) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d windows seen", n_win);
    $fatal(1);
  end

  task automatic send_beat(input logic [7:0] d, input logic sol, input logic eol, input logic [3:0] fr);
    bit got;
    got = 1'b0;
    in_data = d; in_sol = sol; in_eol = eol; frac_in = fr; in_valid = 1'b1;
    for (int t = 0; t < 1000 && !got; t++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
    end
    if (!got) chk("beat_timeout", 64'(got), 64'd1);
    #1;
    in_valid = 1'b0; in_sol = 1'b0; in_eol = 1'b0;
  endtask

  task automatic send_line(input int first, input int n, input logic [3:0] fr);
    for (int i = 0; i < n; i++) send_beat(8'(first + i), i == 0, i == n - 1, fr);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 1000 && exp_q.size() > 0; t++) @(posedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n, m;
    bit ab;
    logic [3:0] fr;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_frac", 64'(out_frac), 64'd0);
    chk("rst_eol", 64'(out_eol), 64'd0);
    chk("rst_x0", 64'(out_x0), 64'd0);
    chk("rst_x5", 64'(out_x5), 64'd0);
    rst_n = 1'b1;
    idle(1);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // line 1..5, frac 7, first window one cycle after s3
    send_beat(8'd1, 1'b1, 1'b0, 4'd7);
    send_beat(8'd2, 1'b0, 1'b0, 4'd0);
    send_beat(8'd3, 1'b0, 1'b0, 4'd0);
    chk("lat_pre", 64'(out_valid), 64'd0);
    send_beat(8'd4, 1'b0, 1'b0, 4'd0);
    chk("lat_post", 64'(out_valid), 64'd1);
    send_beat(8'd5, 1'b0, 1'b1, 4'd0);
    drain();

    // single-sample line
    send_beat(8'h80, 1'b1, 1'b1, 4'd3);
    drain();
    @(negedge clk);
    chk("single_idle_ready", 64'(in_ready), 64'd1);
    idle(1);

    // backpressure in the middle of RUN
    base = n_win;
    fork
      send_line(10, 8, 4'd11);
      begin
        for (int t = 0; t < 200 && n_win < base + 2; t++) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // beats without SOL in IDLE are dropped
    send_beat(8'd9, 1'b0, 1'b0, 4'd0);
    send_beat(8'd9, 1'b0, 1'b0, 4'd0);
    send_line(1, 2, 4'd5);
    drain();

    // SOL after 5 samples of a 10-sample line aborts it
    for (int i = 0; i < 5; i++) send_beat(8'(20 + i), i == 0, 1'b0, 4'd2);
    send_line(40, 6, 4'd9);
    drain();

    // async reset while flushing
    out_ready = 1'b0;
    send_line(1, 4, 4'd1);
    idle(1);
    chk("flush_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_flush_valid", 64'(out_valid), 64'd0);
    chk("rst_flush_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    active = 1'b0;
    idle(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    send_line(30, 3, 4'd6);
    drain();

    // random lines with random gaps, aborts, junk beats and backpressure
    rdy_rand = 1'b1;
    for (int l = 0; l < 40; l++) begin
      n  = $urandom_range(1, 20);
      ab = ($urandom_range(0, 7) == 0);
      m  = ab ? $urandom_range(1, n) : n;
      fr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) send_beat(8'($urandom), 1'b0, 1'b0, 4'd0);
      for (int i = 0; i < m; i++) begin
        send_beat(8'($urandom), i == 0, !ab && i == m - 1, fr);
        idle($urandom_range(0, 2));
      end
    end
    drain();
    rdy_rand = 1'b0;
    idle(2);
    out_ready = 1'b1;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/affine_sample_window.md
Name: affine_sample_window

Overview:
- Upstream feeder for the affine 1/16-precision 6-tap MCM tap filters (tap 0..5).
- Receives a raster stream of signed reference samples, one line at a time.
- Builds a sliding 6-sample window with edge replication and presents one sample per tap (X input of each tap MCM), together with the line's fractional phase.
- Valid/ready on both sides. Exactly N windows are output for an N-sample line.

Parameters:
- IN_SIZE, 8, bit width of input samples and window taps (signed).
- LEN_W, 8, width of the in-line position counter; maximum line length is 2^LEN_W - 4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts the sample this cycle.
- in_data  in  IN_SIZE  signed reference sample.
- in_sol  in  1  start of line; qualifies in_data.
- in_eol  in  1  last sample of line; may coincide with in_sol.
- frac_in  in  4  fractional phase 0..15; sampled with the in_sol beat.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts the window.
- out_x0 .. out_x5  out  IN_SIZE each  window samples; x0 is the oldest and x5 the newest. The centre sample is x2.
- out_frac  out  4  phase latched at SOL.
- out_eol  out  1  marks the last window of the line.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - out_valid=0, out_x0..5=0, out_frac=0, out_eol=0.
  - in_ready=0 while in reset.
  - Window registers and counters are cleared.
- Definitions:
  - s_i is the i-th accepted sample of the line.
  - N is the line length, known at the EOL beat.
  - j is the shift counter.
  - Shift inserts into x5; the other taps move down (x0 <- x1, ..., x4 <- x5).
- IDLE:
  - in_ready=1.
  - A beat without in_sol is dropped.
  - A beat with in_sol does the following: load all six window regs with s0, set j=0, latch frac, then go to FILL. If in_eol is also set, go to FLUSH with N=1.
- FILL (j<3):
  - in_ready=1.
  - Each accepted beat shifts s_{j+1} in and increments j. No output is produced.
  - When j reaches 3, go to RUN. An output is registered on that same shift.
- RUN:
  - in_ready = !out_valid || out_ready.
  - Each accepted beat shifts, increments j, and registers a window; out_valid=1 on the next cycle.
  - The window for j emitted is centre k=j-3.
- EOL beat (any state):
  - Record N = index+1, then go to FLUSH.
- FLUSH:
  - in_ready=0.
  - Each cycle where the output register is free, shift in s_{N-1} (replicated last sample), increment j, and emit if j>=3.
  - Ends when j = N+2. The final window has out_eol=1; then go to IDLE.
  - For N<4, the missing fill shifts also use s_{N-1}. The general rule: the inserted sample is s_min(j,N-1).
- Output register:
  - Holds all of its values stable while out_valid && !out_ready.
  - Cleared when out_ready && no new window.
- Latency: one cycle from the shift beat to out_valid.
- Throughput: one window per cycle when there is no backpressure.
- in_sol in FILL/RUN: abort the current line with no flush, discard the pending window, and restart as in IDLE. A pending out_valid window that is already registered is still delivered.
- in_sol in FLUSH: not possible, because in_ready=0.
- Overflow: a line longer than the max causes j to saturate; behaviour for that line is undefined. This must be flagged by a bench assertion.

Optional Feature:
- Macro: AFFINE_WIN_COL_EN.
- When defined:
  - Extra port out_col  out  LEN_W  gives the centre index k = j-3 for each window.
  - out_col resets to 0.
  - out_col is held stable under backpressure, like the other outputs.
- When undefined: the port is absent and no counter logic beyond j exists.

Test Plan:
- Line 1,2,3,4,5 with frac=7 and no backpressure -> 5 windows:
  - (1,1,1,2,3,4)
  - (1,1,2,3,4,5)
  - (1,2,3,4,5,5)
  - (2,3,4,5,5,5)
  - (3,4,5,5,5,5)
  - out_frac=7 on all; out_eol only on the last window; first out_valid 1 cycle after accepting s3.
- Single beat -128 with sol=eol=1 -> exactly one window with all taps -128, out_eol=1, then IDLE with in_ready=1.
- Line 10..17 with out_ready held low 3 cycles mid-RUN -> outputs stable and in_ready=0 during the stall; sequence identical to the no-stall case; no sample lost or duplicated.
- Beats without in_sol in IDLE (values 9, 9) followed by line 1,2 -> the 9s are dropped; windows (1,1,1,2,2,2) and (1,1,2,2,2,2).
- New in_sol after 5 samples of a 10-sample line -> the old line is aborted with no out_eol, and the new line's windows are correct from its s0.
- rst_n asserted during FLUSH -> out_valid=0 immediately (async); after release the block is in IDLE and a following line outputs correctly.
